lfsr_decrypt_rx: RTL and testbench



---
 rtl/lfsr_decrypt_rx.sv | 118 +++++++++++
 tb/tb_lfsr_decrypt_rx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_decrypt_rx.sv
// Receive-side LFSR stream decryptor: the keystream advances once per accepted data byte,
// frames are bounded by a byte count, and an in-band seed load resynchronises the receiver.
module lfsr_decrypt_rx #(
  parameter logic [7:0] SEED      = 8'h41,
  parameter int         FRAME_LEN = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_seed,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       busy,
  output logic [7:0] byte_count,
  output logic       err_zero_seed,
  output logic       err_drop
);

  typedef enum logic {
    RUN,
    WAIT_SEED
  } state_e;

  localparam logic [7:0] LastIdx = 8'(FRAME_LEN - 1);

  state_e     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] count_q, count_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_last_q, out_last_d;
  logic       err_zero_q, err_zero_d;
  logic       err_drop_q, err_drop_d;

  logic       acc;
  logic [7:0] lfsr_next;

  // Sync waiting never stalls the stream; in RUN the single output slot gates intake.
  assign in_ready  = (state_q == WAIT_SEED) | ~out_valid_q | out_ready;
  assign acc       = in_valid & in_ready;
  assign lfsr_next = {lfsr_q[6:0], lfsr_q[0] ^ lfsr_q[5] ^ lfsr_q[6] ^ lfsr_q[7]};

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    err_zero_d  = 1'b0;
    err_drop_d  = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (acc && in_seed) begin
      if (in_data != 8'h00) begin
        lfsr_d  = in_data;
        count_d = 8'h00;
        state_d = RUN;
      end else begin
        err_zero_d = 1'b1;
        state_d    = WAIT_SEED;
      end
    end else if (acc) begin
      if (state_q == RUN) begin
        out_data_d  = in_data ^ lfsr_q;
        out_valid_d = 1'b1;
        out_last_d  = (count_q == LastIdx);
        lfsr_d      = lfsr_next;
        if (count_q == LastIdx) begin
          count_d = 8'h00;
          state_d = WAIT_SEED;
        end else begin
          count_d = count_q + 8'h01;
        end
      end else begin
        err_drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      lfsr_q      <= SEED;
      count_q     <= 8'h00;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
      err_zero_q  <= 1'b0;
      err_drop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      err_zero_q  <= err_zero_d;
      err_drop_q  <= err_drop_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_last      = out_last_q;
  assign busy          = (state_q == RUN);
  assign byte_count    = count_q;
  assign err_zero_seed = err_zero_q;
  assign err_drop      = err_drop_q;

endmodule

// File: tb/tb_lfsr_decrypt_rx.sv
// Bench for lfsr_decrypt_rx: directed scenarios with literal expectations, then random traffic
// checked every cycle against a frame-position/keystream-index model of the receiver.
module tb_lfsr_decrypt_rx;

  localparam int FRAME_LEN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_seed = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
  logic [7:0] byte_count;
  logic       err_zero_seed;
  logic       err_drop;

  int checkCount = 0;
  int passCount  = 0;

  lfsr_decrypt_rx #(.SEED(8'h41), .FRAME_LEN(FRAME_LEN)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_seed(in_seed),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .byte_count(byte_count),
    .err_zero_seed(err_zero_seed), .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  // Model: the keystream byte for a data byte is the seed stepped once per earlier byte of the frame.
  bit         modelLive = 1'b0;
  bit         mRun, mPend, mLast, mErrZero, mErrDrop;
  logic [7:0] mSeed, mData;
  int         mPos;

  function automatic logic [7:0] keyAt(input logic [7:0] seed, input int n);
    logic [7:0] k = seed;
    for (int i = 0; i < n; i++) k = {k[6:0], k[0] ^ k[5] ^ k[6] ^ k[7]};
    return k;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checkCount++;
    if (act !== exp) $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else passCount++;
  endtask

  initial begin
    bit ready, acc;
    forever begin
      @(posedge clk);
      if (rst) begin
        modelLive = 1'b1;
        mRun = 1'b1; mPend = 1'b0; mLast = 1'b0; mData = 8'h00;
        mSeed = 8'h41; mPos = 0; mErrZero = 1'b0; mErrDrop = 1'b0;
      end else if (modelLive) begin
        ready = !mRun || !mPend || out_ready;
        acc = in_valid && ready;
        mErrZero = 1'b0;
        mErrDrop = 1'b0;
        if (mPend && out_ready) mPend = 1'b0;
        if (acc && in_seed) begin
          if (in_data != 8'h00) begin
            mSeed = in_data; mPos = 0; mRun = 1'b1;
          end else begin
            mErrZero = 1'b1; mRun = 1'b0;
          end
        end else if (acc) begin
          if (mRun) begin
            mData = in_data ^ keyAt(mSeed, mPos);
            mLast = (mPos == FRAME_LEN - 1);
            mPend = 1'b1;
            if (mLast) begin
              mPos = 0; mRun = 1'b0;
            end else begin
              mPos++;
            end
          end else begin
            mErrDrop = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    bit expReady;
    forever begin
      @(negedge clk);
      if (modelLive) begin
        expReady = !mRun || !mPend || out_ready;
        checkOutput("in_ready", {7'd0, in_ready}, {7'd0, expReady});
        checkOutput("out_valid", {7'd0, out_valid}, {7'd0, mPend});
        checkOutput("busy", {7'd0, busy}, {7'd0, mRun});
        checkOutput("byte_count", byte_count, 8'(mPos));
        checkOutput("err_zero_seed", {7'd0, err_zero_seed}, {7'd0, mErrZero});
        checkOutput("err_drop", {7'd0, err_drop}, {7'd0, mErrDrop});
        if (mPend) begin
          checkOutput("out_data", out_data, mData);
          checkOutput("out_last", {7'd0, out_last}, {7'd0, mLast});
        end
      end
    end
  end

  // Offers one byte and returns at posedge+1 just after the edge that accepted it.
  task automatic applyStimulus(input logic [7:0] d, input logic s);
    int  waitCycles = 0;
    logic rdy = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_seed  = s;
    while (!rdy && waitCycles < 50) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      waitCycles++;
    end
    if (!rdy) checkOutput("accept_timeout", 8'h00, 8'h01);
    in_valid = 1'b0;
    in_seed  = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] t1Data [4];
    t1Data = '{8'h41, 8'h82, 8'h05, 8'h0B};

    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_out_valid", {7'd0, out_valid}, 8'h00);
    checkOutput("reset_out_data", out_data, 8'h00);
    checkOutput("reset_busy", {7'd0, busy}, 8'h01);
    checkOutput("reset_count", byte_count, 8'h00);

    $display("[TB] back-to-back keystream bytes");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(t1Data[i], 1'b0);
      checkOutput("t1_out_data", out_data, 8'h00);
      checkOutput("t1_count", byte_count, (i == 3) ? 8'h00 : 8'(i + 1));
    end
    checkOutput("t1_last", {7'd0, out_last}, 8'h01);
    checkOutput("t1_busy", {7'd0, busy}, 8'h00);

    $display("[TB] drop in WAIT_SEED then reseed");
    applyStimulus(8'h33, 1'b0);
    checkOutput("drop_pulse", {7'd0, err_drop}, 8'h01);
    checkOutput("drop_no_out", {7'd0, out_valid}, 8'h00);
    applyStimulus(8'hFF, 1'b1);
    checkOutput("seed_busy", {7'd0, busy}, 8'h01);
    applyStimulus(8'hFF, 1'b0);
    checkOutput("seedff_out0", out_data, 8'h00);
    applyStimulus(8'hFE, 1'b0);
    checkOutput("seedff_out1", out_data, 8'h00);

    $display("[TB] backpressure hold");
    doReset();
    applyStimulus(8'hEB, 1'b0);
    checkOutput("t2_out_data", out_data, 8'hAA);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h90;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold_in_ready", {7'd0, in_ready}, 8'h00);
      checkOutput("hold_out_data", out_data, 8'hAA);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("release_in_ready", {7'd0, in_ready}, 8'h01);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("release_out_data", out_data, 8'h12);

    $display("[TB] zero seed");
    applyStimulus(8'h00, 1'b1);
    checkOutput("zero_seed_pulse", {7'd0, err_zero_seed}, 8'h01);
    checkOutput("zero_seed_busy", {7'd0, busy}, 8'h00);
    applyStimulus(8'h55, 1'b0);
    checkOutput("zero_seed_drop", {7'd0, err_drop}, 8'h01);

    $display("[TB] mid-frame reseed");
    applyStimulus(8'h41, 1'b1);
    applyStimulus(8'h41, 1'b0);
    applyStimulus(8'h82, 1'b0);
    applyStimulus(8'h41, 1'b1);
    checkOutput("reseed_count", byte_count, 8'h00);
    applyStimulus(8'h41, 1'b0);
    checkOutput("reseed_out_data", out_data, 8'h00);
    checkOutput("reseed_out_last", {7'd0, out_last}, 8'h00);

    $display("[TB] reset with pending output");
    applyStimulus(8'h82, 1'b0);
    out_ready = 1'b0;
    doReset();
    checkOutput("rst_out_valid", {7'd0, out_valid}, 8'h00);
    checkOutput("rst_busy", {7'd0, busy}, 8'h01);
    checkOutput("rst_count", byte_count, 8'h00);
    out_ready = 1'b1;
    applyStimulus(8'h41, 1'b0);
    checkOutput("rst_out_data", out_data, 8'h00);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_seed   = ($urandom_range(0, 15) == 0);
      in_data   = (in_seed && $urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 299) == 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
